// File: rtl/ctrl_pkg.sv
// ctrl_pkg: frame constants, FSM encoding, command type and frame helpers for the cmdt transmit path
package ctrl_pkg;
  localparam logic [7:0] FRAME_HDR = 8'hAA;
  localparam int FRAME_LEN = 6;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_GAP} state_t;
  typedef struct packed {
    logic [7:0] dev;
    logic [7:0] mod;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;
  function automatic logic [7:0] cmd_sum(cmd_t c);
    return c.dev + c.mod + c.addr + c.data;
  endfunction
  function automatic logic [7:0] frame_byte(cmd_t c, logic [7:0] sum, logic [2:0] idx);
    return idx == 3'd0 ? FRAME_HDR : idx == 3'd1 ? c.dev : idx == 3'd2 ? c.mod :
           idx == 3'd3 ? c.addr : idx == 3'd4 ? c.data : sum;
  endfunction
endpackage

// File: rtl/cmdt_tx_ser_if.sv
// cmdt_tx_ser_if: command strobe bundle toward the serializer, serial line and status back
interface cmdt_tx_ser_if;
  logic [7:0] cmdt_dev;
  logic [7:0] cmdt_mod;
  logic [7:0] cmdt_addr;
  logic [7:0] cmdt_data;
  logic cmdt_vld;
  logic tx_ctrl;
  logic tx_busy;
  logic tx_drop;
  modport master (output cmdt_dev, cmdt_mod, cmdt_addr, cmdt_data, cmdt_vld, input tx_ctrl, tx_busy, tx_drop);
  modport slave (input cmdt_dev, cmdt_mod, cmdt_addr, cmdt_data, cmdt_vld, output tx_ctrl, tx_busy, tx_drop);
endinterface

// File: rtl/cmd_fifo.sv
// cmd_fifo: single-clock show-ahead FIFO; a push on full is accepted when a pop frees the slot the same cycle
module cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int AW = 2
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic full,
  output logic empty,
  output logic push_ok
);
  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic pop_ok;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q[AW];
    pop_ok = pop && !empty;
    push_ok = push && (!full || pop_ok);
    wr_d = wr_q + AW'(push_ok);
    rd_d = rd_q + AW'(pop_ok);
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    rd_data = mem_q[rd_q];
  end
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
    if (push_ok) mem_q[wr_q] <= wr_data;
  end
endmodule

// File: rtl/cmdt_tx_ser.sv
// cmdt_tx_ser: queues commands and sends each as an AA,dev,mod,addr,data,sum UART frame on tx_ctrl.
// Define CMDT_PARITY_EN for 8E1 framing (even parity bit after the data bits); default is 8N1.
module cmdt_tx_ser import ctrl_pkg::*; #(
  parameter int BIT_US = 8,
  parameter int FIFO_AW = 2,
  parameter int GAP_BITS = 2
) (
  input logic clk_sys,
  input logic rst,
  input logic pluse_us,
  cmdt_tx_ser_if.slave bus
);
  localparam int UW = $clog2(BIT_US + 1);
  localparam int GW = $clog2(GAP_BITS + 1);
  state_t state_q, state_d;
  logic [UW-1:0] us_q, us_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0] bit_q, bit_d, idx_q, idx_d;
  logic [7:0] sh_q, sh_d, sum_q, sum_d;
  cmd_t cmd_q, cmd_d;
  logic tx_q, tx_d, busy_q, busy_d, drop_q, drop_d;
  logic bit_end, pop, full, empty, push_ok;
  logic [31:0] rd_data;
  assign pop = state_q == ST_LOAD;
  cmd_fifo #(.WIDTH(32), .AW(FIFO_AW)) u_fifo (
    .clk_sys(clk_sys), .rst(rst), .push(bus.cmdt_vld), .pop(pop),
    .wr_data({bus.cmdt_dev, bus.cmdt_mod, bus.cmdt_addr, bus.cmdt_data}),
    .rd_data(rd_data), .full(full), .empty(empty), .push_ok(push_ok)
  );
  always_comb begin
    state_d = state_q;
    us_d = us_q;
    gap_d = gap_q;
    bit_d = bit_q;
    idx_d = idx_q;
    sh_d = sh_q;
    sum_d = sum_q;
    cmd_d = cmd_q;
    tx_d = tx_q;
    bit_end = pluse_us && us_q == UW'(BIT_US - 1);
    if (state_q != ST_IDLE && state_q != ST_LOAD && pluse_us) us_d = bit_end ? '0 : us_q + 1'b1;
    case (state_q)
      ST_IDLE: state_d = empty ? ST_IDLE : ST_LOAD;
      ST_LOAD: begin
        cmd_d = cmd_t'(rd_data);
        sum_d = cmd_sum(cmd_t'(rd_data));
        idx_d = '0;
        sh_d = FRAME_HDR;
        us_d = '0;
        tx_d = 1'b0;
        state_d = ST_START;
      end
      ST_START: if (bit_end) begin
        tx_d = sh_q[0];
        sh_d = sh_q >> 1;
        bit_d = '0;
        state_d = ST_DATA;
      end
      ST_DATA: if (bit_end) begin
        if (bit_q == 3'd7) begin
`ifdef CMDT_PARITY_EN
          tx_d = ^frame_byte(cmd_q, sum_q, idx_q);
          state_d = ST_PAR;
`else
          tx_d = 1'b1;
          state_d = ST_STOP;
`endif
        end else begin
          tx_d = sh_q[0];
          sh_d = sh_q >> 1;
          bit_d = bit_q + 1'b1;
        end
      end
`ifdef CMDT_PARITY_EN
      ST_PAR: if (bit_end) begin
        tx_d = 1'b1;
        state_d = ST_STOP;
      end
`endif
      ST_STOP: if (bit_end) begin
        if (idx_q == 3'(FRAME_LEN - 1)) begin
          gap_d = '0;
          state_d = ST_GAP;
        end else begin
          idx_d = idx_q + 1'b1;
          sh_d = frame_byte(cmd_q, sum_q, idx_q + 3'd1);
          tx_d = 1'b0;
          state_d = ST_START;
        end
      end
      ST_GAP: if (bit_end) begin
        if (gap_q == GW'(GAP_BITS - 1)) state_d = ST_IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // push_ok covers the cycle a command lands in an empty FIFO while idle
    busy_d = state_d != ST_IDLE || !empty || push_ok;
    drop_d = bus.cmdt_vld && full && !pop;
  end
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= ST_IDLE;
      us_q <= '0;
      gap_q <= '0;
      bit_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      sum_q <= '0;
      cmd_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      us_q <= us_d;
      gap_q <= gap_d;
      bit_q <= bit_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      sum_q <= sum_d;
      cmd_q <= cmd_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      drop_q <= drop_d;
    end
  end
  assign bus.tx_ctrl = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_drop = drop_q;
endmodule
